// File: rtl/pwm_bank_if.sv
// Host-side channel write / commit bus for pwm_bank.
// The front end is the master; the PWM engine consumes the bus as slave.
interface pwm_bank_if #(
  parameter int WIDTH = 12,
  parameter int CH_W  = 4
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_on;
  logic [WIDTH-1:0] wr_off;
  logic             wr_full_on;
  logic             wr_full_off;
  logic             commit;
  logic             update_mode;

  modport master (
    output wr_en, wr_ch, wr_on, wr_off, wr_full_on, wr_full_off, commit, update_mode
  );

  modport slave (
    input wr_en, wr_ch, wr_on, wr_off, wr_full_on, wr_full_off, commit, update_mode
  );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM engine: a shared prescaled step counter, per-channel shadow/active
// on/off windows, a registered level stage and a combinational invert/output-enable pad mux.
module pwm_bank #(
  parameter int CHANNELS   = 16,
  parameter int WIDTH      = 12,
  parameter int PRESCALE_W = 8,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pwm_bank_if.slave             host,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  invert_i,
  input  logic                  oe_ni,
  input  logic [1:0]            outne_i,
  input  logic                  outdrv_i,
  output logic [CHANNELS-1:0]   pwm_o,
  output logic [CHANNELS-1:0]   pad_en_o,
  output logic [WIDTH-1:0]      counter_o,
  output logic                  period_start_o,
  output logic                  pending_o
);
  typedef struct packed {
    logic [WIDTH-1:0] on;
    logic [WIDTH-1:0] off;
    logic             full_on;
    logic             full_off;
  } chan_cfg_t;

  localparam chan_cfg_t CfgReset = '{on: '0, off: '0, full_on: 1'b0, full_off: 1'b1};

  logic [PRESCALE_W-1:0]     pre_cnt_q, pre_cnt_d, prescale_eff;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      period_start_q, period_start_d;
  logic                      pending_q, pending_d;
  chan_cfg_t [CHANNELS-1:0]  shadow_q, shadow_d;
  chan_cfg_t [CHANNELS-1:0]  active_q, active_d;
  logic [CHANNELS-1:0]       lvl_q, lvl_d;
  logic [CHANNELS-1:0]       pwm_raw;
  logic                      pre_term, wrap, transfer;

  // The >= terminal compare lets a lowered prescale take effect without a long stall.
  always_comb begin
    prescale_eff   = (prescale_i < PRESCALE_W'(3)) ? PRESCALE_W'(3) : prescale_i;
    pre_term       = (pre_cnt_q >= prescale_eff);
    pre_cnt_d      = pre_term ? '0 : pre_cnt_q + PRESCALE_W'(1);
    cnt_d          = pre_term ? cnt_q + WIDTH'(1) : cnt_q;
    wrap           = pre_term && (cnt_q == '1);
    period_start_d = wrap;
  end

  // Transfer uses the next shadow value so a write landing on the transfer edge is included.
  always_comb begin
    shadow_d = shadow_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (host.wr_en && (host.wr_ch == CH_W'(c))) begin
        shadow_d[c] = '{on:       host.wr_on,
                        off:      host.wr_off,
                        full_on:  host.wr_full_on,
                        full_off: host.wr_full_off};
      end
    end
    transfer  = pending_q && (host.update_mode || wrap);
    active_d  = transfer ? shadow_d : active_q;
    pending_d = transfer ? 1'b0 : (pending_q || host.commit);
  end

  always_comb begin
    lvl_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (active_q[c].full_off) begin
        lvl_d[c] = 1'b0;
      end else if (active_q[c].full_on) begin
        lvl_d[c] = 1'b1;
      end else if (active_q[c].on == active_q[c].off) begin
        lvl_d[c] = 1'b0;
      end else if (active_q[c].on < active_q[c].off) begin
        lvl_d[c] = (cnt_q >= active_q[c].on) && (cnt_q < active_q[c].off);
      end else begin
        lvl_d[c] = (cnt_q >= active_q[c].on) || (cnt_q < active_q[c].off);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      pending_q      <= 1'b0;
      shadow_q       <= {CHANNELS{CfgReset}};
      active_q       <= {CHANNELS{CfgReset}};
      lvl_q          <= '0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
      pending_q      <= pending_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      lvl_q          <= lvl_d;
    end
  end

  // Pad mux stays combinational so oe/invert/outne act without a clock of delay.
  always_comb begin
    pwm_raw  = lvl_q ^ {CHANNELS{invert_i}};
    pwm_o    = '0;
    pad_en_o = '0;
    if (!oe_ni) begin
      if (outdrv_i) begin
        pwm_o    = pwm_raw;
        pad_en_o = '1;
      end else begin
        pad_en_o = ~pwm_raw;
      end
    end else begin
      case (outne_i)
        2'b00: pad_en_o = '1;
        2'b01: begin
          if (outdrv_i) begin
            pwm_o    = '1;
            pad_en_o = '1;
          end
        end
        default: pad_en_o = '0;
      endcase
    end
  end

  assign counter_o      = cnt_q;
  assign period_start_o = period_start_q;
  assign pending_o      = pending_q;
endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank (4 channels, 4-bit counter, 3-bit channel index
// so out-of-range indices can be driven) against a cycle-level behavioural model.
module tb_pwm_bank;
  localparam int CHANNELS   = 4;
  localparam int WIDTH      = 4;
  localparam int PRESCALE_W = 8;
  localparam int CH_W       = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [PRESCALE_W-1:0] prescale;
  logic                  invert, oe_n, outdrv;
  logic [1:0]            outne;
  logic [CHANNELS-1:0]   pwm_o, pad_en_o;
  logic [WIDTH-1:0]      counter_o;
  logic                  period_start_o, pending_o;

  always #5 clk = ~clk;

  pwm_bank_if #(.WIDTH(WIDTH), .CH_W(CH_W)) host ();

  pwm_bank #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W), .CH_W(CH_W)) dut (
    .clk_i(clk), .rst_i(rst), .host(host), .prescale_i(prescale), .invert_i(invert),
    .oe_ni(oe_n), .outne_i(outne), .outdrv_i(outdrv), .pwm_o(pwm_o), .pad_en_o(pad_en_o),
    .counter_o(counter_o), .period_start_o(period_start_o), .pending_o(pending_o)
  );

  typedef struct { int on; int off; bit fon; bit foff; } cfg_t;

  cfg_t       m_sh [CHANNELS];
  cfg_t       m_act[CHANNELS];
  int         m_pre, m_cnt;
  bit         m_ps, m_pend;
  logic [3:0] m_lvl;
  int         checks = 0;
  int         errors = 0;

  // Window membership as modular distance from the on step: covers plain, wrapped and empty windows.
  function automatic bit win_high(cfg_t c, int cnt);
    if (c.foff) return 1'b0;
    if (c.fon) return 1'b1;
    return ((cnt - c.on + 16) % 16) < ((c.off - c.on + 16) % 16);
  endfunction

  function automatic logic [13:0] model_vec();
    logic [3:0] raw, p, e;
    raw = m_lvl ^ {4{invert}};
    p = 4'h0;
    e = 4'h0;
    if (!oe_n) begin
      if (outdrv) begin p = raw; e = 4'hf; end
      else e = ~raw;
    end else if (outne == 2'b00) begin
      e = 4'hf;
    end else if (outne == 2'b01 && outdrv) begin
      p = 4'hf; e = 4'hf;
    end
    return {4'(m_cnt), m_ps, m_pend, p, e};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {counter_o, period_start_o, pending_o, pwm_o, pad_en_o};
  endfunction

  task automatic clk_step();
    cfg_t       n_sh [CHANNELS];
    cfg_t       n_act[CHANNELS];
    int         n_pre, n_cnt, p;
    bit         n_ps, n_pend, wrap, xfer;
    logic [3:0] n_lvl;
    if (rst) begin
      n_pre = 0; n_cnt = 0; n_ps = 0; n_pend = 0; n_lvl = 4'h0;
      foreach (n_sh[i]) n_sh[i] = '{0, 0, 1'b0, 1'b1};
      n_act = n_sh;
    end else begin
      p = (prescale < 3) ? 3 : int'(prescale);
      wrap = 1'b0;
      if (m_pre >= p) begin
        n_pre = 0;
        n_cnt = (m_cnt + 1) % 16;
        wrap  = (n_cnt == 0);
      end else begin
        n_pre = m_pre + 1;
        n_cnt = m_cnt;
      end
      n_ps = wrap;
      for (int i = 0; i < CHANNELS; i++) n_lvl[i] = win_high(m_act[i], m_cnt);
      n_sh = m_sh;
      if (host.wr_en && int'(host.wr_ch) < CHANNELS)
        n_sh[int'(host.wr_ch)] = '{int'(host.wr_on), int'(host.wr_off), host.wr_full_on, host.wr_full_off};
      xfer = m_pend && (host.update_mode || wrap);
      if (xfer) n_act = n_sh;
      else n_act = m_act;
      n_pend = xfer ? 1'b0 : (m_pend || host.commit);
    end
    @(posedge clk);
    m_pre = n_pre; m_cnt = n_cnt; m_ps = n_ps; m_pend = n_pend; m_lvl = n_lvl;
    m_sh = n_sh; m_act = n_act;
    #1;
  endtask

  task automatic do_write(int ch, int on, int off, bit fon, bit foff);
    host.wr_en = 1'b1; host.wr_ch = 3'(ch); host.wr_on = 4'(on); host.wr_off = 4'(off);
    host.wr_full_on = fon; host.wr_full_off = foff;
    clk_step();
    host.wr_en = 1'b0;
  endtask

  task automatic do_commit(bit mode);
    host.update_mode = mode; host.commit = 1'b1;
    clk_step();
    host.commit = 1'b0;
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst = 1'b1; prescale = 8'd3;
    repeat (3) clk_step();
    checks++;
    if ({counter_o, period_start_o, pending_o, pwm_o, pad_en_o} !== 14'h000f) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 14'h000f);
    end
    rst = 1'b0;
    for (int i = 1; i <= 130; i++) begin
      clk_step();
      if (period_start_o === 1'b1) pulses++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL reset_run cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      if (i == 6) begin
        checks++;
        if (counter_o !== 4'd1) begin errors++; $display("FAIL reset_step: counter %0d expected 1", counter_o); end
      end
      checks++;
      if (pwm_o !== 4'h0) begin errors++; $display("FAIL reset_pwm cyc %0d: got %h expected 0", i, pwm_o); end
    end
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL reset_period_pulses: got %0d expected 2", pulses); end
  endtask

  task automatic test_windows();
    int prev;
    do_write(0, 2, 5, 1'b0, 1'b0);
    do_write(1, 12, 3, 1'b0, 1'b0);
    do_commit(1'b1);
    checks++;
    if (pending_o !== 1'b1) begin errors++; $display("FAIL windows_pending_set: got %b expected 1", pending_o); end
    clk_step();
    checks++;
    if (pending_o !== 1'b0) begin errors++; $display("FAIL windows_pending_clr: got %b expected 0", pending_o); end
    for (int i = 0; i < 70; i++) begin
      prev = m_cnt;
      clk_step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL windows_vec cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      checks++;
      if (pwm_o[1:0] !== {(prev >= 12 || prev < 3), (prev >= 2 && prev < 5)}) begin
        errors++; $display("FAIL windows_levels step %0d: got %b", prev, pwm_o[1:0]);
      end
    end
  endtask

  task automatic test_mode0();
    int  n = 0;
    bit  seen_wrap = 1'b0, second = 1'b0;
    while (counter_o !== 4'd7 && n < 200) begin clk_step(); n++; end
    checks++;
    if (counter_o !== 4'd7) begin errors++; $display("FAIL mode0_wait: counter %0d expected 7", counter_o); end
    host.wr_en = 1'b1; host.wr_ch = 3'd0; host.wr_on = 4'd10; host.wr_off = 4'd14;
    host.wr_full_on = 1'b0; host.wr_full_off = 1'b0;
    host.update_mode = 1'b0; host.commit = 1'b1;
    clk_step();
    host.wr_en = 1'b0; host.commit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      host.commit = (!second && counter_o === 4'd9);
      if (host.commit) second = 1'b1;
      clk_step();
      host.commit = 1'b0;
      if (period_start_o === 1'b1) seen_wrap = 1'b1;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL mode0_vec cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      checks++;
      if (pending_o !== !seen_wrap) begin
        errors++; $display("FAIL mode0_pending cyc %0d: got %b expected %b", i, pending_o, !seen_wrap);
      end
    end
    checks++;
    if (!(seen_wrap && second)) begin errors++; $display("FAIL mode0_events: wrap %b second %b", seen_wrap, second); end
  endtask

  task automatic test_edges();
    int prev;
    do_write(3, 0, 8, 1'b1, 1'b1);
    do_write(2, 6, 6, 1'b0, 1'b0);
    do_write(0, 2, 5, 1'b0, 1'b0);
    do_write(5, 0, 8, 1'b1, 1'b0);
    do_commit(1'b1);
    clk_step();
    for (int i = 0; i < 70; i++) begin
      prev = m_cnt;
      clk_step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL edges_vec cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      checks++;
      if (pwm_o !== {1'b0, 1'b0, (prev >= 12 || prev < 3), (prev >= 2 && prev < 5)}) begin
        errors++; $display("FAIL edges_levels step %0d: got %b", prev, pwm_o);
      end
    end
  endtask

  task automatic test_prescale();
    int c0, n;
    prescale = 8'd10;
    c0 = m_cnt; n = 0;
    while (counter_o === 4'(c0) && n < 40) begin clk_step(); n++; end
    c0 = m_cnt; n = 0;
    while (counter_o === 4'(c0) && n < 40) begin clk_step(); n++; end
    checks++;
    if (n != 11) begin errors++; $display("FAIL prescale_10: step took %0d clocks expected 11", n); end
    repeat (8) clk_step();
    prescale = 8'd4;
    c0 = m_cnt;
    clk_step();
    checks++;
    if (counter_o !== 4'(c0 + 1)) begin
      errors++; $display("FAIL prescale_drop: counter %0d expected %0d", counter_o, (c0 + 1) % 16);
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 2) prescale = 8'd0;
      c0 = m_cnt; n = 0;
      do begin
        clk_step(); n++;
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++; $display("FAIL prescale_vec: got %h expected %h", dut_vec(), model_vec());
        end
      end while (counter_o === 4'(c0) && n < 40);
      checks++;
      if (n != ((k == 2) ? 4 : 5)) begin
        errors++; $display("FAIL prescale_len %0d: got %0d clocks expected %0d", k, n, (k == 2) ? 4 : 5);
      end
    end
    prescale = 8'd3;
  endtask

  task automatic test_outputs();
    oe_n = 1'b1; outne = 2'b00; outdrv = 1'b1; invert = 1'b0; #1;
    checks++;
    if ({pwm_o, pad_en_o} !== 8'h0f) begin errors++; $display("FAIL out_dis00: got %h expected 0f", {pwm_o, pad_en_o}); end
    outne = 2'b01; #1;
    checks++;
    if ({pwm_o, pad_en_o} !== 8'hff) begin errors++; $display("FAIL out_dis01: got %h expected ff", {pwm_o, pad_en_o}); end
    outne = 2'b10; #1;
    checks++;
    if (pad_en_o !== 4'h0) begin errors++; $display("FAIL out_dis10: pad %h expected 0", pad_en_o); end
    oe_n = 1'b0; invert = 1'b1; #1;
    checks++;
    if (pwm_o !== ~m_lvl) begin errors++; $display("FAIL out_invert: got %h expected %h", pwm_o, ~m_lvl); end
    outdrv = 1'b0; #1;
    checks++;
    if ({pwm_o, pad_en_o} !== {4'h0, m_lvl}) begin
      errors++; $display("FAIL out_opendrain: got %h expected %h", {pwm_o, pad_en_o}, {4'h0, m_lvl});
    end
    for (int i = 0; i < 60; i++) begin
      oe_n = 1'($urandom_range(1)); outne = 2'($urandom_range(3));
      outdrv = 1'($urandom_range(1)); invert = 1'($urandom_range(1));
      clk_step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL out_rand cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    oe_n = 1'b0; outne = 2'b00; outdrv = 1'b1; invert = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      host.wr_en       = ($urandom_range(2) == 0);
      host.wr_ch       = 3'($urandom_range(7));
      host.wr_on       = 4'($urandom_range(15));
      host.wr_off      = 4'($urandom_range(15));
      host.wr_full_on  = ($urandom_range(7) == 0);
      host.wr_full_off = ($urandom_range(7) == 0);
      host.commit      = ($urandom_range(9) == 0);
      host.update_mode = 1'($urandom_range(1));
      if ($urandom_range(29) == 0) prescale = 8'($urandom_range(6));
      clk_step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    host.wr_en = 1'b0; host.commit = 1'b0; prescale = 8'd3;
  endtask

  task automatic test_reset_mid();
    do_write(0, 1, 9, 1'b1, 1'b0);
    do_commit(1'b0);
    repeat (5) clk_step();
    rst = 1'b1;
    clk_step();
    checks++;
    if ({counter_o, period_start_o, pending_o, pwm_o, pad_en_o} !== 14'h000f) begin
      errors++; $display("FAIL reset_mid: got %h expected %h", dut_vec(), 14'h000f);
    end
    rst = 1'b0;
    do_commit(1'b1);
    for (int i = 0; i < 40; i++) begin
      clk_step();
      checks++;
      if (pwm_o !== 4'h0 || dut_vec() !== model_vec()) begin
        errors++; $display("FAIL reset_mid_run cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; prescale = 8'd3; invert = 1'b0; oe_n = 1'b0; outne = 2'b00; outdrv = 1'b1;
    host.wr_en = 1'b0; host.wr_ch = '0; host.wr_on = '0; host.wr_off = '0;
    host.wr_full_on = 1'b0; host.wr_full_off = 1'b0; host.commit = 1'b0; host.update_mode = 1'b1;
    test_reset();
    test_windows();
    test_mode0();
    test_edges();
    test_prescale();
    test_outputs();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d errors", errors);
    $fatal(1, "time limit");
  end
endmodule
